// File: rtl/xor_parity_accum.sv
// xor_parity_accum: serial parity accumulator behind the my_xor stage.
// Collects FRAME_LEN qualified bits, counts the ones, and reports parity
// with a one-cycle done strobe once the frame is complete.
module xor_parity_accum #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x_in,
  input  logic             valid_in,
  output logic             busy,
  output logic             done,
  output logic             parity_out,
  output logic [CNT_W-1:0] ones_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [1:0]       state;
  logic             acc;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ones_next;
  logic             acc_next;

  // Running values including the bit currently presented.
  always_comb begin
    acc_next  = acc ^ x_in;
    ones_next = ones + CNT_W'(x_in);
  end

  // Frame sequencing, accumulation and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= 1'b0;
      ones       <= '0;
      cnt        <= '0;
      parity_out <= 1'b0;
      ones_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= 1'b0;
            ones  <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          if (valid_in) begin
            acc  <= acc_next;
            ones <= ones_next;
            if (cnt == LAST_IDX) begin
              // cnt is left at its last index so it never reaches FRAME_LEN
              parity_out <= acc_next;
              ones_count <= ones_next;
              state      <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= 1'b0;
            ones  <= '0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decode from state only.
  always_comb begin
    busy = (state == ACCUM);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_xor_parity_accum.sv
// Self-checking bench for xor_parity_accum: directed scenarios plus random
// frames, with expected results derived from the list of accepted bits.
module tb_xor_parity_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, x8, v8;
  logic       busy8, done8, par8;
  logic [3:0] ones8;
  logic       start255, x255, v255;
  logic       busy255, done255, par255;
  logic [7:0] ones255;

  int checks = 0;
  int errors = 0;
  int exp_ones8 = 0;
  int exp_par8  = 0;

  always #5 clk = ~clk;

  xor_parity_accum #(.FRAME_LEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x_in(x8), .valid_in(v8),
    .busy(busy8), .done(done8), .parity_out(par8), .ones_count(ones8)
  );

  xor_parity_accum #(.FRAME_LEN(255)) dut255 (
    .clk(clk), .rst(rst), .start(start255), .x_in(x255), .valid_in(v255),
    .busy(busy255), .done(done255), .parity_out(par255), .ones_count(ones255)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Outputs of the 8-bit instance while a frame is in progress.
  task automatic chk_accum8(input string tag);
    chk({tag, "_busy"}, 32'(busy8), 1);
    chk({tag, "_done"}, 32'(done8), 0);
    chk({tag, "_hold_ones"}, 32'(ones8), 32'(exp_ones8));
    chk({tag, "_hold_par"}, 32'(par8), 32'(exp_par8));
  endtask

  task automatic begin_frame8;
    start8 = 1'b1; x8 = 1'($urandom); v8 = 1'($urandom);
    tick;
    chk_accum8("start");
  endtask

  // gap_mode: 0 none, 1 one gap before every bit (x=1), 2 random gaps.
  // Frame bits are fed pat[7] first. Random start pulses inside ACCUM must be ignored.
  task automatic frame8(input logic [7:0] pat, input int gap_mode, input bit hold_start);
    int n;
    for (int i = 0; i < 8; i++) begin
      n = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < n; g++) begin
        v8 = 1'b0; x8 = (gap_mode == 1) ? 1'b1 : 1'($urandom); start8 = 1'($urandom);
        tick;
        chk_accum8("gap");
      end
      v8 = 1'b1; x8 = pat[7-i]; start8 = 1'($urandom);
      tick;
      if (i < 7) chk_accum8("bit");
    end
    exp_ones8 = $countones(pat);
    exp_par8  = int'(^pat);
    chk("done_strobe", 32'(done8), 1);
    chk("done_busy", 32'(busy8), 0);
    chk("ones_count", 32'(ones8), 32'(exp_ones8));
    chk("parity", 32'(par8), 32'(exp_par8));
    // A bit offered in DONE must not leak into the next frame.
    v8 = 1'b1; x8 = 1'b1; start8 = hold_start;
    tick;
    chk("post_done", 32'(done8), 0);
    chk("post_busy", 32'(busy8), 32'(hold_start));
    chk("post_ones", 32'(ones8), 32'(exp_ones8));
    chk("post_par", 32'(par8), 32'(exp_par8));
    start8 = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    bit         hold;

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start8 = 1'($urandom); x8 = 1'($urandom); v8 = 1'($urandom);
      start255 = 1'($urandom); x255 = 1'($urandom); v255 = 1'($urandom);
      tick;
    end
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_par", 32'(par8), 0);
    chk("rst_ones", 32'(ones8), 0);
    chk("rst255_busy", 32'(busy255), 0);
    chk("rst255_ones", 32'(ones255), 0);
    rst = 1'b0; start8 = 1'b0; start255 = 1'b0; v255 = 1'b0; x255 = 1'b0;

    // Idle: data ignored, nothing starts
    for (int i = 0; i < 3; i++) begin
      x8 = 1'($urandom); v8 = 1'($urandom);
      tick;
      chk("idle_busy", 32'(busy8), 0);
      chk("idle_done", 32'(done8), 0);
    end

    // Basic frame 1,0,1,1,0,0,1,0
    begin_frame8;
    frame8(8'b1011_0010, 0, 1'b0);

    // Gapped frame 1,1,1,0,0,0,0,0 with x_in=1 in the gaps
    begin_frame8;
    frame8(8'b1110_0000, 1, 1'b0);

    // All-ones, 8 bits
    begin_frame8;
    frame8(8'hFF, 0, 1'b0);

    // Reset after 5 accepted bits
    begin_frame8;
    for (int i = 0; i < 5; i++) begin
      v8 = 1'b1; x8 = 1'b1;
      tick;
      chk_accum8("pre_rst");
    end
    rst = 1'b1; start8 = 1'b1; v8 = 1'b1;
    tick;
    rst = 1'b0; start8 = 1'b0;
    exp_ones8 = 0; exp_par8 = 0;
    chk("midrst_busy", 32'(busy8), 0);
    chk("midrst_done", 32'(done8), 0);
    chk("midrst_ones", 32'(ones8), 0);
    chk("midrst_par", 32'(par8), 0);
    for (int i = 0; i < 4; i++) begin
      x8 = 1'($urandom); v8 = 1'($urandom);
      tick;
      chk("midrst_nodone", 32'(done8), 0);
    end
    begin_frame8;
    frame8(8'b1000_0000, 0, 1'b0);

    // Back-to-back frames with start held through DONE
    begin_frame8;
    frame8(8'b0111_0110, 2, 1'b1);
    frame8(8'b0000_0100, 2, 1'b1);
    frame8(8'b1111_1110, 0, 1'b0);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      pat = 8'($urandom);
      hold = 1'($urandom);
      if (!busy8) begin_frame8;
      frame8(pat, 2, hold);
    end
    if (busy8) frame8(8'h5A, 0, 1'b0);

    // FRAME_LEN=255, all ones
    start255 = 1'b1;
    tick;
    start255 = 1'b0;
    chk("f255_busy", 32'(busy255), 1);
    for (int i = 0; i < 255; i++) begin
      v255 = 1'b1; x255 = 1'b1;
      tick;
      if (i < 254) begin
        if (done255 !== 1'b0 || busy255 !== 1'b1) chk("f255_early", {busy255, done255}, 32'b10);
      end
    end
    chk("f255_done", 32'(done255), 1);
    chk("f255_ones", 32'(ones255), 255);
    chk("f255_par", 32'(par255), 1);
    v255 = 1'b0;
    tick;
    chk("f255_post_done", 32'(done255), 0);
    chk("f255_post_busy", 32'(busy255), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_parity_accum.md
# xor_parity_accum

Serial parity accumulator that consumes the single-bit output of the `my_xor` gate stage. It collects a fixed-length frame of qualified bits, counts the ones, and reports the frame's even/odd parity with a one-cycle completion strobe. It is the next lab stage after the combinational XOR: it adds clocked state, a counter and a start/done handshake around the same XOR function.

## Interface
- `FRAME_LEN`, default 8: bits per frame; legal range 2..255.
- `CNT_W`, default `$clog2(FRAME_LEN+1)`: counter and ones-count width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high; overrides every other input.
- `start`, input, 1: begin a new frame; sampled only in IDLE or DONE.
- `x_in`, input, 1: data bit, driven by the XOR stage output `x`.
- `valid_in`, input, 1: `x_in` qualifier; a bit is accepted on an edge where `valid_in=1` in ACCUM.
- `busy`, output, 1: high while in ACCUM.
- `done`, output, 1: one-cycle strobe, high only in DONE.
- `parity_out`, output, 1: XOR of all bits of the last completed frame (1 = odd number of ones); held until the next `done`.
- `ones_count`, output, CNT_W: number of ones in the last completed frame; held until the next `done`.

## Operation
- **States:** IDLE, ACCUM, DONE; 2-bit state register; encoding is free.
- **Internal registers:**
  - `acc`: 1-bit running XOR.
  - `ones`: CNT_W running count of ones.
  - `cnt`: CNT_W count of accepted bits.
- **IDLE:**
  - `busy=0`, `done=0`; `x_in` and `valid_in` are ignored.
  - `start=1` → ACCUM, with `acc=0`, `ones=0`, `cnt=0`.
- **ACCUM:**
  - `busy=1`. Each accepted bit updates `acc <= acc ^ x_in`, `ones <= ones + x_in`, `cnt <= cnt + 1`.
  - `valid_in=0` cycles hold all registers. There is no timeout.
  - `start` is ignored.
  - When the accepted bit is the last one (`cnt == FRAME_LEN-1`), on the same edge:
    - `parity_out <= acc ^ x_in`;
    - `ones_count <= ones + x_in`;
    - state → DONE.
- **DONE:**
  - `done=1`, `busy=0`; lasts exactly one cycle.
  - Next state is ACCUM if `start=1` (registers cleared as from IDLE, giving back-to-back frames); otherwise IDLE.
  - A bit presented in DONE is never accepted, even if `start=1`.
- **Width rule:** `ones_count` must represent FRAME_LEN exactly, so an all-ones frame never wraps to 0. `cnt` never exceeds FRAME_LEN-1.
- **Reset:**
  - `rst=1` on any edge → IDLE.
  - `busy=0`, `done=0`, `parity_out=0`, `ones_count=0`, and all internal registers 0.
  - A partial frame is discarded; no `done` is produced for it.
- **Simultaneous events:** `rst` beats `start` and `valid_in`. `start` in ACCUM has no effect, including on the last-bit edge.

## Timing
- **Reset values:** `busy=0`, `done=0`, `parity_out=0`, `ones_count=0`.
- **Start latency:** `start` sampled at edge E → `busy=1` after E. The first bit can be accepted at edge E+1.
- **Completion latency:** last bit accepted at edge N → after N: `done=1`, `parity_out` and `ones_count` valid. After edge N+1, `done=0`.
- **Frame length:** minimum frame time is FRAME_LEN+1 cycles from the `start` edge to the `done` edge. With `start` held in DONE, one idle bit slot separates consecutive frames.
- **Output registration:** all outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Test plan
- **Reset:** `rst=1` for 2 cycles with random inputs → `busy=0`, `done=0`, `parity_out=0`, `ones_count=0`.
- **Basic frame:** FRAME_LEN=8, `start`, then bits 1,0,1,1,0,0,1,0 with `valid_in=1` every cycle → `done` one cycle after the 8th edge, `ones_count=4`, `parity_out=0`; `busy` high for exactly 8 cycles.
- **Gapped frame:** bits 1,1,1,0,0,0,0,0 with `valid_in` low on alternate cycles, and `x_in=1` during the gaps → `ones_count=3`, `parity_out=1`; gap bits are not counted.
- **All-ones boundary:** FRAME_LEN=8, eight 1s → `ones_count=8` (4'b1000), `parity_out=0`. Then FRAME_LEN=255, all ones → `ones_count=255`, `parity_out=1`.
- **Reset mid-frame:** reset after 5 accepted bits → IDLE, no `done`, outputs 0. A following frame of 1,0,0,0,0,0,0,0 gives `ones_count=1`, `parity_out=1`.
- **Back-to-back and ignored start:** pulse `start` during ACCUM → no effect. Hold `start=1` through DONE → a second frame begins immediately; results update only on the second `done`, and the first result is held until then.
